// File: rtl/expr_parser.sv
// expr_parser: ASCII "<type><src1><op><src2>=" parser with error reporting and valid/ready result hold; optional err_cnt port via PARSER_ERR_CNT_EN
module expr_parser #(
   parameter int         DATA_W   = 8,
   parameter logic [3:0] DEF_TYPE = 4'h8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] src1,
   output logic [DATA_W-1:0] src2,
   output logic [4:0]        operator,
   output logic [3:0]        data_type,
`ifdef PARSER_ERR_CNT_EN
   output logic [7:0]        err_cnt,
`endif
   output logic              err
);
   localparam int MAX_DIG = DATA_W / 4;
   localparam int CW = $clog2(MAX_DIG + 1);
   localparam logic [CW-1:0] MAXC = CW'(MAX_DIG);
   typedef enum logic [2:0] {S_TYPE, S_SRC1, S_SRC2, S_ERR, S_HOLD} state_t;
   state_t state, nxt;
   logic [CW-1:0] cnt1, cnt2;
   logic take, is_sp, is_eq, is_dig, ok_end, done;
   logic [3:0] nib, typ_c;
   logic [4:0] op_c;
   assign in_ready  = state != S_HOLD;
   assign out_valid = state == S_HOLD;
   assign done      = out_valid && out_ready;
   // decode the incoming byte and choose the next parser state
   always_comb begin
      take   = in_valid && in_ready;
      is_sp  = in_data == 8'h20;
      is_eq  = in_data == 8'h3D;
      is_dig = (in_data >= 8'h30 && in_data <= 8'h39) || (in_data >= 8'h41 && in_data <= 8'h46) ||
               (in_data >= 8'h61 && in_data <= 8'h66);
      nib    = in_data <= 8'h39 ? in_data[3:0] : in_data[3:0] + 4'd9;
      op_c   = in_data == 8'h2B ? 5'h10 : in_data == 8'h2D ? 5'h08 : in_data == 8'h2A ? 5'h04 :
               in_data == 8'h2F ? 5'h02 : in_data == 8'h25 ? 5'h01 : in_data == 8'h26 ? 5'h11 :
               in_data == 8'h7C ? 5'h12 : in_data == 8'h5E ? 5'h14 : 5'h00;
      typ_c  = in_data == 8'h49 ? 4'h8 : in_data == 8'h46 ? 4'h4 : in_data == 8'h55 ? 4'h2 :
               in_data == 8'h53 ? 4'h1 : 4'h0;
      nxt    = state;
      ok_end = 1'b0;
      if (state == S_HOLD)
         nxt = out_ready ? S_TYPE : S_HOLD;
      else if (take && !is_sp)
         case (state)
            S_TYPE: nxt = typ_c != 4'h0 ? S_TYPE : is_dig ? S_SRC1 : is_eq ? S_HOLD : S_ERR;
            S_SRC1: nxt = is_dig ? (cnt1 == MAXC ? S_ERR : S_SRC1) : op_c != 5'h00 ? S_SRC2 :
                          is_eq ? S_HOLD : S_ERR;
            S_SRC2: begin
               nxt    = is_dig ? (cnt2 == MAXC ? S_ERR : S_SRC2) : is_eq ? S_HOLD : S_ERR;
               ok_end = is_eq && cnt2 != '0;
            end
            default: nxt = is_eq ? S_HOLD : S_ERR;
         endcase
   end
   // parser state register
   always_ff @(posedge clk) begin
      if (rst) state <= S_TYPE;
      else     state <= nxt;
   end
   // accumulate operands, operator and type flags; finalise or zero them on entry to S_HOLD
   always_ff @(posedge clk) begin
      if (rst || done) begin
         src1      <= '0;
         src2      <= '0;
         operator  <= '0;
         data_type <= '0;
         err       <= 1'b0;
         cnt1      <= '0;
         cnt2      <= '0;
      end else if (take && !is_sp) begin
         if (nxt == S_HOLD) begin
            err <= !ok_end;
            if (ok_end) data_type <= data_type == 4'h0 ? DEF_TYPE : data_type;
            else begin
               src1      <= '0;
               src2      <= '0;
               operator  <= '0;
               data_type <= '0;
            end
         end else begin
            if (state == S_TYPE && nxt == S_TYPE) data_type <= data_type | typ_c;
            if (state == S_SRC1 && nxt == S_SRC2) operator <= op_c;
            if (is_dig && nxt == S_SRC1) begin
               src1 <= (src1 << 4) | DATA_W'(nib);
               cnt1 <= cnt1 + 1'b1;
            end
            if (is_dig && nxt == S_SRC2) begin
               src2 <= (src2 << 4) | DATA_W'(nib);
               cnt2 <= cnt2 + 1'b1;
            end
         end
      end
   end
`ifdef PARSER_ERR_CNT_EN
   // count handshaken error results, saturating
   always_ff @(posedge clk) begin
      if (rst) err_cnt <= '0;
      else if (done && err && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
   end
`endif
endmodule
